ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit for the multi-cycle RV64 core; the sending end of the fetch-to-decode valid/ready interface.
- Holds the PC and issues one read per instruction on a simple AR/R read channel to instruction memory.
- Extracts the 32-bit instruction and presents it with its PC to the decoder. Waits for the execute/writeback path to return the next PC before fetching again.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- ADDR_W, 64, PC and address width.
- DATA_W, 64, memory read-data width; only 32 and 64 are legal.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- araddr_o  out  ADDR_W  read address, aligned to DATA_W/8
- arvalid_o  out  1  read request valid
- arready_i  in  1  memory accepts the request
- rdata_i  in  DATA_W  read data
- rresp_i  in  2  response code; nonzero means access fault
- rvalid_i  in  1  read data valid
- rready_o  out  1  unit accepts read data
- inst_o  out  32  fetched instruction
- pc_o  out  ADDR_W  PC of inst_o
- fault_o  out  1  instruction-access or misaligned-fetch fault for inst_o
- d_valid_o  out  1  instruction available to the decoder
- d_ready_i  in  1  decoder accepts
- npc_valid_i  in  1  next PC is available (end of the current instruction)
- npc_i  in  ADDR_W  next PC

Behaviour:
- Clock and reset: one clock `clock`; `reset` is synchronous, active-high.
- Reset values: pc=RESET_PC, state=S_REQ, inst_o=0, fault_o=0, d_valid_o=0, rready_o=0. arvalid_o is 1 from the first cycle after reset deasserts.
- Reset mid-operation: returns to S_REQ immediately. Any in-flight R beat is dropped; memory is reset by the same signal.
- FSM, 4 states, all outputs registered or decoded from state:
  - S_REQ: arvalid_o=1, araddr_o = pc with its low log2(DATA_W/8) bits cleared; the address is held stable until the handshake. On arvalid_o & arready_i, go to S_RESP.
  - S_RESP: rready_o=1. On rvalid_i, capture the instruction and fault=(rresp_i!=0), then go to S_HOLD.
  - S_HOLD: d_valid_o=1. inst_o, pc_o and fault_o are stable while d_valid_o & !d_ready_i. On d_valid_o & d_ready_i, go to S_WAIT.
  - S_WAIT: d_valid_o=0, no memory activity. On npc_valid_i, pc<=npc_i and go to S_REQ.
- Instruction selection: for DATA_W=64, inst = pc[2] ? rdata_i[63:32] : rdata_i[31:0]. For DATA_W=32, inst = rdata_i.
- Fault on the fetch: inst_o is forced to 32'h0000_0000 and fault_o=1. The handshake to the decoder is unchanged.
- Misaligned next PC (npc_i[1:0]!=0, no C extension):
  - pc<=npc_i; no memory request is issued.
  - S_WAIT goes directly to S_HOLD with fault_o=1 and inst_o=0.
- npc_valid_i outside S_WAIT is ignored, PC unchanged.
- arready_i in the same cycle arvalid_o rises: one-cycle request. Back-to-back rvalid_i in the S_REQ->S_RESP transition cycle is not expected and is ignored.
- Latency: reset release -> arvalid_o next cycle. Best case arready_i=1 and rvalid_i one cycle later: d_valid_o 3 cycles after the request starts. npc_valid_i -> arvalid_o next cycle.
- pc_o always equals the PC of the instruction being presented. The PC increments only via npc_i; there is no internal +4.

Decomposition:
- Shared defines header:
  - ysyx_23060251 inst/addr bus widths.
  - RESET_PC default.
  - rresp OKAY encoding (2'b00).
  - FSM state encoding (S_REQ, S_RESP, S_HOLD, S_WAIT).
  - NOP/fault instruction constant.
- No sub-module; the word select is a few lines inline.

Test Plan:
- Reset then arready_i=1, rvalid_i next cycle, rdata_i=64'h00000013_00100093, rresp=0, d_ready_i=1 -> araddr_o=0x8000_0000; inst_o=0x00100093, pc_o=0x8000_0000, fault_o=0.
- npc_i=0x8000_0004 with rdata_i=64'h00000013_00100093 -> araddr_o=0x8000_0000; inst_o=0x00000013, pc_o=0x8000_0004.
- d_ready_i held 0 for 5 cycles in S_HOLD -> d_valid_o, inst_o and pc_o stable all 5 cycles; one transfer on ready.
- rresp_i=2'b10 -> inst_o=0, fault_o=1, d_valid_o=1; the next npc fetches normally with fault_o=0.
- npc_i=0x8000_0002 -> no arvalid_o; d_valid_o next cycle with fault_o=1, pc_o=0x8000_0002.
- reset asserted in S_RESP with rvalid_i pending -> next cycle state=S_REQ, pc=RESET_PC, d_valid_o=0, rready_o=0. A spurious npc_valid_i in S_REQ leaves the PC unchanged.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared widths, reset PC, response encoding, FSM states and the fault instruction
// used by the instruction fetch unit.
package ifu_pkg;

  localparam int INST_W = 32;
  localparam int XLEN   = 64;

  localparam logic [63:0]       RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [1:0]        RRESP_OKAY   = 2'b00;
  localparam logic [INST_W-1:0] INST_FAULT   = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2,
    S_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch: one AR/R read per instruction, then hold for decode and wait for the next PC.
// Request to decode-valid is three cycles best case; d_ready_i low holds inst/pc/fault stable.
module ifu
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = XLEN,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fault_o,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  input  logic              npc_valid_i,
  input  logic [ADDR_W-1:0] npc_i
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                fault_q, fault_d;
  logic                hi_word;
  logic [INST_W-1:0]   word_sel;
  logic                rsp_fault;

  // A 32-bit bus always returns the instruction in the only word it has.
  assign hi_word   = (DATA_W == 64) && pc_q[2];
  assign word_sel  = hi_word ? rdata_i[DATA_W-1 -: INST_W] : rdata_i[INST_W-1:0];
  assign rsp_fault = (rresp_i != RRESP_OKAY);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      S_REQ: begin
        if (arvalid_o && arready_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (rvalid_i) begin
          inst_d  = rsp_fault ? INST_FAULT : word_sel;
          fault_d = rsp_fault;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (d_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (npc_valid_i) begin
          pc_d = npc_i;
          // Without compressed instructions a misaligned target never touches memory.
          if (npc_i[1:0] != 2'b00) begin
            inst_d  = INST_FAULT;
            fault_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= INST_FAULT;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // Request is held off while reset is high so memory never sees one during reset.
  assign arvalid_o = (state_q == S_REQ) && !reset;
  assign araddr_o  = pc_q & ALIGN_MASK;
  assign rready_o  = (state_q == S_RESP);
  assign d_valid_o = (state_q == S_HOLD);
  assign inst_o    = inst_q;
  assign pc_o      = pc_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a transaction-level model of the fetch contract is compared every cycle,
// with literal expectations from the fetch scenarios pinning the model.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [63:0] rdata_i = '0;
  logic [1:0]  rresp_i = 2'b00;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        fault_o;
  logic        d_valid_o;
  logic        d_ready_i = 1'b0;
  logic        npc_valid_i = 1'b0;
  logic [63:0] npc_i = '0;

  ifu dut (
    .clock      (clock),
    .reset      (reset),
    .araddr_o   (araddr_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready_i),
    .rdata_i    (rdata_i),
    .rresp_i    (rresp_i),
    .rvalid_i   (rvalid_i),
    .rready_o   (rready_o),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .fault_o    (fault_o),
    .d_valid_o  (d_valid_o),
    .d_ready_i  (d_ready_i),
    .npc_valid_i(npc_valid_i),
    .npc_i      (npc_i)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_req  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Model: which phase the fetch contract is in, plus the instruction owed to decode.
  logic [63:0] m_pc   = RST_PC;
  bit          m_req  = 1'b1;
  bit          m_resp = 1'b0;
  bit          m_hold = 1'b0;
  logic [31:0] m_inst = '0;
  bit          m_fault = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_req = 1'b1; m_resp = 1'b0; m_hold = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("arvalid", arvalid_o, m_req);
      check("rready", rready_o, m_resp);
      check("d_valid", d_valid_o, m_hold);
      check("pc", pc_o, m_pc);
      if (arvalid_o) check("araddr", araddr_o, m_pc & ~64'h7);
      if (m_hold) begin
        check("inst", inst_o, m_inst);
        check("fault", fault_o, m_fault);
      end
    end
  end

  task automatic wait_arvalid();
    int n = 0;
    @(negedge clock);
    while (!arvalid_o && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("arvalid_seen", arvalid_o, 1);
  endtask

  task automatic fetch(input logic [63:0] rdata, input logic [1:0] resp, input int ar_delay);
    wait_arvalid();
    t_req = cyc;
    repeat (ar_delay) @(negedge clock);
    arready_i = 1'b1;
    @(posedge clock); #1;
    arready_i = 1'b0; m_req = 1'b0; m_resp = 1'b1;
    rvalid_i = 1'b1; rdata_i = rdata; rresp_i = resp;
    @(posedge clock); #1;
    rvalid_i = 1'b0; rresp_i = 2'b00;
    m_resp = 1'b0; m_hold = 1'b1;
    m_fault = (resp != 2'b00);
    m_inst = m_fault ? 32'h0 : (m_pc[2] ? rdata[63:32] : rdata[31:0]);
  endtask

  task automatic consume(input int stall);
    int hi = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      if (d_valid_o) hi++;
    end
    check("stall_valid_cycles", hi, stall);
    d_ready_i = 1'b1;
    @(posedge clock); #1;
    d_ready_i = 1'b0; m_hold = 1'b0;
    @(negedge clock);
    check("single_transfer", d_valid_o, 0);
  endtask

  task automatic next_pc(input logic [63:0] npc);
    npc_valid_i = 1'b1; npc_i = npc;
    @(posedge clock); #1;
    npc_valid_i = 1'b0;
    m_pc = npc;
    if (npc[1:0] != 2'b00) begin
      m_hold = 1'b1; m_inst = 32'h0; m_fault = 1'b1;
    end else begin
      m_req = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_d_valid", d_valid_o, 0);
    check("rst_rready", rready_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_pc", pc_o, RST_PC);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("arvalid_after_reset", arvalid_o, 1);
    check("first_araddr", araddr_o, 64'h8000_0000);

    // Lower word at an 8-byte aligned PC, best-case memory timing.
    fetch(64'h00000013_00100093, 2'b00, 0);
    check("req_to_dvalid_cycles", cyc - t_req + 1, 3);
    check("f1_inst", inst_o, 32'h00100093);
    check("f1_pc", pc_o, 64'h8000_0000);
    check("f1_fault", fault_o, 0);
    consume(0);

    // Upper word: address is still the aligned doubleword.
    next_pc(64'h8000_0004);
    check("f2_araddr", araddr_o, 64'h8000_0000);
    fetch(64'h00000013_00100093, 2'b00, 2);
    check("f2_inst", inst_o, 32'h00000013);
    check("f2_pc", pc_o, 64'h8000_0004);
    consume(5);

    // Access fault then a normal fetch.
    next_pc(64'h8000_0008);
    fetch(64'hAAAAAAAA_BBBBBBBB, 2'b10, 0);
    check("f3_inst", inst_o, 32'h0);
    check("f3_fault", fault_o, 1);
    check("f3_dvalid", d_valid_o, 1);
    consume(1);
    next_pc(64'h8000_000C);
    fetch(64'h00a00513_12345678, 2'b00, 1);
    check("f4_inst", inst_o, 32'h00a00513);
    check("f4_fault", fault_o, 0);
    consume(0);

    // Misaligned target: no request, straight to decode with a fault.
    next_pc(64'h8000_0002);
    check("mis_no_arvalid", arvalid_o, 0);
    @(negedge clock);
    check("mis_dvalid", d_valid_o, 1);
    check("mis_fault", fault_o, 1);
    check("mis_pc", pc_o, 64'h8000_0002);
    check("mis_inst", inst_o, 32'h0);
    consume(0);

    // Reset while a response beat is pending.
    next_pc(64'h8000_0010);
    wait_arvalid();
    arready_i = 1'b1;
    @(posedge clock); #1;
    arready_i = 1'b0; m_req = 1'b0; m_resp = 1'b1;
    @(negedge clock); #1;
    rvalid_i = 1'b1; rdata_i = 64'h11111111_22222222;
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    rvalid_i = 1'b0;
    @(negedge clock);
    check("midrst_rready", rready_o, 0);
    check("midrst_dvalid", d_valid_o, 0);
    check("midrst_pc", pc_o, RST_PC);
    @(posedge clock); #1;
    reset = 1'b0;
    npc_valid_i = 1'b1; npc_i = 64'h1234_0000;
    @(posedge clock); #1;
    npc_valid_i = 1'b0;
    check("spurious_npc_pc", pc_o, RST_PC);
    check("spurious_npc_araddr", araddr_o, 64'h8000_0000);
    fetch(64'h00000013_00100093, 2'b00, 0);
    check("post_rst_inst", inst_o, 32'h00100093);
    consume(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
